ps2_kb_fifo_rx: RTL and testbench

Parametrised PS/2 keyboard receiver with a buffered key-event queue. It samples the raw PS2Clk/PS2Data lines, deframes and validates 11-bit frames, and folds E0/F0 prefixes into single key events. Events are queued in a show-ahead FIFO for the CPU-side keyboard I/O port. It is the generalised successor to the fixed-width keyboard front end, adding configurable depth, glitch filtering, timeout recovery, error and overflow reporting, and extended-key support.

---
 rtl/ps2_kb_fifo_rx.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ps2_kb_fifo_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_fifo_rx.sv
// PS/2 keyboard receiver: synchronise/filter, frame deserialiser, E0/F0 decoder, show-ahead queue.
// Optional build macro KB_BREAK_EVENTS_EN queues break-prefixed keys instead of dropping them.
`timescale 1ns/1ps
module ps2_kb_fifo_rx #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_US  = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PS2Clk,
    input  logic               PS2Data,
    input  logic               KB_read_en,
    input  logic               KB_clear,
    output logic               KB_status,
    output logic [9:0]         KB_data,
    output logic               buf_full,
    output logic [FIFO_AW:0]   fill_level,
    output logic               overflow,
    output logic               frame_err
);

    localparam int unsigned DEPTH       = 2 ** FIFO_AW;
    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FW          = $clog2(FILT_LEN + 1);
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_s, dat_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2Clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2Data};
        end
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe_q;

    // The filtered clock flips only once FILT_LEN samples in a row disagree with it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            strobe_q   <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            strobe_q   <= filt_q & ~filt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout;

    assign timeout = (state_q == StRecv) && (to_cnt_q >= TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (strobe_q && !dat_s) begin
                    state_d   = StRecv;
                    bit_cnt_d = '0;
                end
            end
            StRecv: begin
                if (strobe_q) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        shift_d = {dat_s, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        parity_d = dat_s;
                    end else begin
                        state_d = StIdle;
                        // Odd parity over data+parity, and stop bit must be high.
                        if (((^shift_q) ^ parity_q) & dat_s) begin
                            byte_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                    to_cnt_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       push_q, push_d;
    logic [9:0] push_data_q, push_data_d;

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (KB_clear) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid_q) begin
            case (shift_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'h00, 8'hFF: begin
                    // Keyboard overrun codes: discarded, prefixes kept.
                end
                default: begin
`ifdef KB_BREAK_EVENTS_EN
                    push_d      = 1'b1;
                    push_data_d = {brk_q, ext_q, shift_q};
`else
                    // Break bit is never stored in this build, so KB_data[9] stays 0.
                    push_d      = ~brk_q;
                    push_data_d = {1'b0, ext_q, shift_q};
`endif
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead event queue
    // ------------------------------------------------------------------
    logic [9:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               full, do_push, do_pop;

    assign full    = (count_q == DEPTH_L);
    assign do_pop  = KB_read_en && (count_q != '0) && !KB_clear;
    assign do_push = push_q && !KB_clear && (!full || do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (KB_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push_q && full && !do_pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_q;
    end

    assign KB_status  = (count_q != '0);
    assign KB_data    = KB_status ? mem_q[rd_ptr_q] : 10'h000;
    assign buf_full   = full;
    assign fill_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_kb_fifo_rx.sv
// Directed bench for ps2_kb_fifo_rx: framing, prefixes, errors, timeout, queue limits, reset.
`timescale 1ns/1ps
module tb_ps2_kb_fifo_rx;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n, PS2Clk, PS2Data, KB_read_en, KB_clear;
    logic       KB_status, buf_full, overflow, frame_err;
    logic [9:0] KB_data;
    logic [4:0] fill_level;

    int checks = 0;
    int passes = 0;
    int err_cnt = 0;

    ps2_kb_fifo_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PS2Clk     (PS2Clk),
        .PS2Data    (PS2Data),
        .KB_read_en (KB_read_en),
        .KB_clear   (KB_clear),
        .KB_status  (KB_status),
        .KB_data    (KB_data),
        .buf_full   (buf_full),
        .fill_level (fill_level),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err) err_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        PS2Data = b;
        cyc(HALF);
        PS2Clk = 1'b0;
        cyc(HALF);
        PS2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        cyc(HALF);
    endtask

    task automatic pop();
        KB_read_en = 1'b1;
        cyc(1);
        KB_read_en = 1'b0;
    endtask

    task automatic wait_status(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (KB_status) begin
                timed_out = 1'b0;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset();
        checks++; if (KB_status !== 1'b0) $display("FAIL reset_status got %b exp 0", KB_status); else passes++;
        checks++; if (KB_data !== 10'h000) $display("FAIL reset_data got %h exp 000", KB_data); else passes++;
        checks++; if (fill_level !== 5'd0) $display("FAIL reset_fill got %0d exp 0", fill_level); else passes++;
        checks++; if ({buf_full, overflow, frame_err} !== 3'b000)
            $display("FAIL reset_flags got %b exp 000", {buf_full, overflow, frame_err}); else passes++;
    endtask

    task automatic test_single_frame();
        bit to;
        send_frame(8'h1C, 1'b0);
        wait_status(to);
        checks++; if (to) $display("FAIL single_status got timeout exp KB_status=1"); else passes++;
        checks++; if (KB_data !== 10'h01C) $display("FAIL single_data got %h exp 01C", KB_data); else passes++;
        checks++; if (fill_level !== 5'd1) $display("FAIL single_fill got %0d exp 1", fill_level); else passes++;
        pop();
        checks++; if (KB_status !== 1'b0) $display("FAIL single_pop_status got %b exp 0", KB_status); else passes++;
        checks++; if (fill_level !== 5'd0) $display("FAIL single_pop_fill got %0d exp 0", fill_level); else passes++;
    endtask

    task automatic test_prefixes();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++; if (fill_level !== 5'd1) $display("FAIL ext_fill got %0d exp 1", fill_level); else passes++;
        checks++; if (KB_data !== 10'h175) $display("FAIL ext_data got %h exp 175", KB_data); else passes++;
        pop();
        // Overrun code between prefix and key must leave the prefix pending.
        send_frame(8'hE0, 1'b0);
        send_frame(8'h00, 1'b0);
        send_frame(8'h6B, 1'b0);
        checks++; if (KB_data !== 10'h16B) $display("FAIL ovr_code_data got %h exp 16B", KB_data); else passes++;
        pop();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
`ifdef KB_BREAK_EVENTS_EN
        checks++; if (KB_data !== 10'h21C) $display("FAIL brk_data got %h exp 21C", KB_data); else passes++;
        pop();
`else
        checks++; if (fill_level !== 5'd0) $display("FAIL brk_drop_fill got %0d exp 0", fill_level); else passes++;
`endif
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
`ifdef KB_BREAK_EVENTS_EN
        checks++; if (KB_data !== 10'h375) $display("FAIL extbrk_data got %h exp 375", KB_data); else passes++;
        pop();
`endif
        send_frame(8'h1C, 1'b0);
        checks++; if (KB_data !== 10'h01C) $display("FAIL flags_cleared got %h exp 01C", KB_data); else passes++;
        pop();
    endtask

    task automatic test_parity_err();
        int e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        checks++; if (err_cnt - e0 !== 1) $display("FAIL parity_err_pulses got %0d exp 1", err_cnt - e0); else passes++;
        checks++; if (fill_level !== 5'd0) $display("FAIL parity_fill got %0d exp 0", fill_level); else passes++;
        send_frame(8'h32, 1'b0);
        checks++; if (KB_data !== 10'h032) $display("FAIL parity_next got %h exp 032", KB_data); else passes++;
        pop();
    endtask

    task automatic test_timeout();
        int e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        PS2Data = 1'b1;
        cyc(15000);
        checks++; if (err_cnt - e0 !== 0) $display("FAIL timeout_early got %0d exp 0", err_cnt - e0); else passes++;
        cyc(10000);
        checks++; if (err_cnt - e0 !== 1) $display("FAIL timeout_pulse got %0d exp 1", err_cnt - e0); else passes++;
        send_frame(8'h1C, 1'b0);
        checks++; if (KB_data !== 10'h01C) $display("FAIL timeout_next got %h exp 01C", KB_data); else passes++;
        checks++; if (err_cnt - e0 !== 1) $display("FAIL timeout_next_err got %0d exp 1", err_cnt - e0); else passes++;
        pop();
    endtask

    task automatic test_overflow();
        logic [9:0] exp;
        for (int i = 0; i < 16; i++) send_frame(8'(8'h15 + i), 1'b0);
        checks++; if (fill_level !== 5'd16) $display("FAIL full_fill got %0d exp 16", fill_level); else passes++;
        checks++; if ({buf_full, overflow} !== 2'b10)
            $display("FAIL full_flags got %b exp 10", {buf_full, overflow}); else passes++;
        send_frame(8'h25, 1'b0);
        checks++; if (fill_level !== 5'd16) $display("FAIL ovf_fill got %0d exp 16", fill_level); else passes++;
        checks++; if ({buf_full, overflow} !== 2'b11)
            $display("FAIL ovf_flags got %b exp 11", {buf_full, overflow}); else passes++;
        checks++; if (KB_data !== 10'h015) $display("FAIL ovf_head got %h exp 015", KB_data); else passes++;
        pop();
        pop();
        checks++; if (KB_data !== 10'h017) $display("FAIL pop2_head got %h exp 017", KB_data); else passes++;
        checks++; if (fill_level !== 5'd14) $display("FAIL pop2_fill got %0d exp 14", fill_level); else passes++;
        send_frame(8'h30, 1'b0);
        send_frame(8'h31, 1'b0);
        checks++; if (buf_full !== 1'b1) $display("FAIL refill_full got %b exp 1", buf_full); else passes++;
        // Drain across the pointer wrap.
        for (int i = 0; i < 16; i++) begin
            exp = (i < 14) ? 10'(10'h017 + i) : 10'(10'h030 + (i - 14));
            checks++; if (KB_data !== exp) $display("FAIL drain_%0d got %h exp %h", i, KB_data, exp); else passes++;
            pop();
        end
        checks++; if ({KB_status, overflow} !== 2'b01)
            $display("FAIL drained_flags got %b exp 01", {KB_status, overflow}); else passes++;
        send_frame(8'h40, 1'b0);
        KB_clear = 1'b1;
        cyc(1);
        KB_clear = 1'b0;
        checks++; if ({KB_status, buf_full, overflow} !== 3'b000)
            $display("FAIL clear_flags got %b exp 000", {KB_status, buf_full, overflow}); else passes++;
        checks++; if (fill_level !== 5'd0) $display("FAIL clear_fill got %0d exp 0", fill_level); else passes++;
    endtask

    task automatic test_glitch();
        int e0 = err_cnt;
        PS2Data = 1'b0;
        cyc(5);
        PS2Clk = 1'b0;
        cyc(2);
        PS2Clk = 1'b1;
        cyc(20);
        PS2Data = 1'b1;
        cyc(20);
        send_frame(8'h1C, 1'b0);
        checks++; if (KB_data !== 10'h01C) $display("FAIL glitch_data got %h exp 01C", KB_data); else passes++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL glitch_err got %0d exp 0", err_cnt - e0); else passes++;
        pop();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h1C, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        checks++; if ({KB_status, buf_full, overflow, frame_err} !== 4'b0000)
            $display("FAIL rst_mid_flags got %b exp 0000", {KB_status, buf_full, overflow, frame_err}); else passes++;
        checks++; if ({KB_data, fill_level} !== 15'h0)
            $display("FAIL rst_mid_data got %h/%0d exp 000/0", KB_data, fill_level); else passes++;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        send_frame(8'h1C, 1'b0);
        checks++; if (fill_level !== 5'd1) $display("FAIL rst_next_fill got %0d exp 1", fill_level); else passes++;
        checks++; if (KB_data !== 10'h01C) $display("FAIL rst_next_data got %h exp 01C", KB_data); else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        PS2Clk = 1'b1;
        PS2Data = 1'b1;
        KB_read_en = 1'b0;
        KB_clear = 1'b0;
        cyc(5);
        rst_n = 1'b1;
        cyc(2);
        test_reset();
        test_single_frame();
        test_prefixes();
        test_parity_err();
        test_timeout();
        test_overflow();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got no finish exp finish before 5ms");
        $fatal(1, "watchdog");
    end

endmodule
